hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit_if.sv | 37 +++
 rtl/hazard_control_unit.sv | 117 +++++++++++
 tb/tb_hazard_control_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side signal bundle for the hazard control unit: register/hazard
// inputs from the pipeline and the stall/flush/freeze controls back to it.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       i_rs1_IFID;
    logic [4:0]       i_rs2_IFID;
    logic [4:0]       i_rd_IDEX;
    logic             i_clu_MemRead_IDEX;
    logic             i_branch_taken_EX;
    logic             i_dmem_busy;
    logic             o_pc_write;
    logic             o_IFID_write;
    logic             o_IDEX_bubble;
    logic             o_flush_IFID;
    logic             o_flush_IDEX;
    logic             o_pipe_freeze;
    logic [1:0]       o_state;
    logic [CNT_W-1:0] o_stall_count;
    logic [CNT_W-1:0] o_flush_count;

    modport master (
        output i_rs1_IFID, i_rs2_IFID, i_rd_IDEX,
        output i_clu_MemRead_IDEX, i_branch_taken_EX, i_dmem_busy,
        input  o_pc_write, o_IFID_write, o_IDEX_bubble,
        input  o_flush_IFID, o_flush_IDEX, o_pipe_freeze,
        input  o_state, o_stall_count, o_flush_count
    );

    modport slave (
        input  i_rs1_IFID, i_rs2_IFID, i_rd_IDEX,
        input  i_clu_MemRead_IDEX, i_branch_taken_EX, i_dmem_busy,
        output o_pc_write, o_IFID_write, o_IDEX_bubble,
        output o_flush_IFID, o_flush_IDEX, o_pipe_freeze,
        output o_state, o_stall_count, o_flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// whole-pipeline freeze while data memory is busy, with event counters.
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    hazard_control_unit_if.slave  hcu
);
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        FLUSH  = 2'b01,
        FREEZE = 2'b10
    } state_t;

    localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state, ret_state, next_state, next_ret, eff_state;
    logic [1:0] flush_left, next_left;
    logic       pending, next_pending;
    logic       stall_inc, flush_inc;
    logic       load_use, releasing, branch_eff;

    assign load_use = hcu.i_clu_MemRead_IDEX && (hcu.i_rd_IDEX != 5'd0) &&
                      ((hcu.i_rd_IDEX == hcu.i_rs1_IFID) ||
                       (hcu.i_rd_IDEX == hcu.i_rs2_IFID));

    // On the first non-busy FREEZE cycle the saved state's rules apply, and a
    // branch that arrived during the freeze is replayed as if it were live.
    assign releasing  = (state == FREEZE) && !hcu.i_dmem_busy;
    assign eff_state  = releasing ? ret_state : state;
    assign branch_eff = hcu.i_branch_taken_EX || (releasing && pending);

    always_comb begin
        hcu.o_pc_write    = 1'b1;
        hcu.o_IFID_write  = 1'b1;
        hcu.o_IDEX_bubble = 1'b0;
        hcu.o_flush_IFID  = 1'b0;
        hcu.o_flush_IDEX  = 1'b0;
        hcu.o_pipe_freeze = 1'b0;
        next_state        = state;
        next_ret          = ret_state;
        next_left         = flush_left;
        next_pending      = releasing ? 1'b0 : pending;
        stall_inc         = 1'b0;
        flush_inc         = 1'b0;

        if (!(state inside {RUN, FLUSH, FREEZE})) begin
            next_state   = RUN;
            next_ret     = RUN;
            next_left    = 2'd0;
            next_pending = 1'b0;
        end else if (hcu.i_dmem_busy) begin
            hcu.o_pc_write    = 1'b0;
            hcu.o_IFID_write  = 1'b0;
            hcu.o_pipe_freeze = 1'b1;
            next_state        = FREEZE;
            if (state != FREEZE)
                next_ret = state;
            if (hcu.i_branch_taken_EX)
                next_pending = 1'b1;
        end else if (eff_state == FLUSH) begin
            hcu.o_flush_IFID = 1'b1;
            hcu.o_flush_IDEX = 1'b1;
            if (branch_eff && RELOAD != 2'd0) begin
                next_left  = RELOAD;
                next_state = FLUSH;
            end else if (branch_eff || flush_left <= 2'd1) begin
                next_left  = 2'd0;
                next_state = RUN;
            end else begin
                next_left  = flush_left - 2'd1;
                next_state = FLUSH;
            end
        end else begin
            next_state = RUN;
            if (branch_eff) begin
                hcu.o_flush_IFID = 1'b1;
                hcu.o_flush_IDEX = 1'b1;
                flush_inc        = 1'b1;
                if (RELOAD != 2'd0) begin
                    next_state = FLUSH;
                    next_left  = RELOAD;
                end
            end else if (load_use) begin
                hcu.o_pc_write    = 1'b0;
                hcu.o_IFID_write  = 1'b0;
                hcu.o_IDEX_bubble = 1'b1;
                stall_inc         = 1'b1;
            end
        end
    end

    assign hcu.o_state = state;

    // Counters saturate at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= RUN;
            ret_state         <= RUN;
            flush_left        <= 2'd0;
            pending           <= 1'b0;
            hcu.o_stall_count <= '0;
            hcu.o_flush_count <= '0;
        end else begin
            state      <= next_state;
            ret_state  <= next_ret;
            flush_left <= next_left;
            pending    <= next_pending;
            if (stall_inc && hcu.o_stall_count != '1)
                hcu.o_stall_count <= hcu.o_stall_count + CNT_W'(1);
            if (flush_inc && hcu.o_flush_count != '1)
                hcu.o_flush_count <= hcu.o_flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: three instances with different
// flush lengths and counter widths, checked against hand-computed values.
module tb_hazard_control_unit;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hazard_control_unit_if #(.CNT_W(4))  bus1 ();
    hazard_control_unit_if #(.CNT_W(16)) bus2 ();
    hazard_control_unit_if #(.CNT_W(16)) bus3 ();

    hazard_control_unit #(.FLUSH_CYCLES(1), .CNT_W(4)) u_fc1 (
        .i_clk (clk), .i_rst (rst), .hcu (bus1)
    );
    hazard_control_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u_fc2 (
        .i_clk (clk), .i_rst (rst), .hcu (bus2)
    );
    hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_W(16)) u_fc3 (
        .i_clk (clk), .i_rst (rst), .hcu (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic mem_read,
                                 input logic branch, input logic busy);
        bus1.i_rs1_IFID         = rs1;
        bus1.i_rs2_IFID         = rs2;
        bus1.i_rd_IDEX          = rd;
        bus1.i_clu_MemRead_IDEX = mem_read;
        bus1.i_branch_taken_EX  = branch;
        bus1.i_dmem_busy        = busy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int flush_cycles;
        int freeze_cycles;
        logic [7:0] busy_pat;

        rst = 1'b1;
        bus2.i_rs1_IFID = 5'd0; bus2.i_rs2_IFID = 5'd0; bus2.i_rd_IDEX = 5'd0;
        bus2.i_clu_MemRead_IDEX = 1'b0; bus2.i_branch_taken_EX = 1'b0; bus2.i_dmem_busy = 1'b0;
        bus3.i_rs1_IFID = 5'd0; bus3.i_rs2_IFID = 5'd0; bus3.i_rd_IDEX = 5'd0;
        bus3.i_clu_MemRead_IDEX = 1'b0; bus3.i_branch_taken_EX = 1'b0; bus3.i_dmem_busy = 1'b0;
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("reset_state", 32'(bus1.o_state), 32'd0);
        checkOutput("reset_pc_write", 32'(bus1.o_pc_write), 32'd1);
        checkOutput("reset_stall_count", 32'(bus1.o_stall_count), 32'd0);
        checkOutput("reset_flush_count", 32'(bus1.o_flush_count), 32'd0);
        #9;
        rst = 1'b0;
        tick();

        // Two-cycle flush, then a branch during FLUSH reloads without counting.
        bus2.i_branch_taken_EX = 1'b1;
        #1;
        checkOutput("fc2_flush_ifid_c0", 32'(bus2.o_flush_IFID), 32'd1);
        checkOutput("fc2_flush_idex_c0", 32'(bus2.o_flush_IDEX), 32'd1);
        tick();
        bus2.i_branch_taken_EX = 1'b0;
        #1;
        checkOutput("fc2_state_flush", 32'(bus2.o_state), 32'd1);
        checkOutput("fc2_flush_ifid_c1", 32'(bus2.o_flush_IFID), 32'd1);
        tick();
        checkOutput("fc2_state_back", 32'(bus2.o_state), 32'd0);
        checkOutput("fc2_flush_ifid_c2", 32'(bus2.o_flush_IFID), 32'd0);
        checkOutput("fc2_flush_count", 32'(bus2.o_flush_count), 32'd1);
        bus2.i_branch_taken_EX = 1'b1;
        tick();
        tick();
        checkOutput("fc2_reload_state", 32'(bus2.o_state), 32'd1);
        bus2.i_branch_taken_EX = 1'b0;
        tick();
        checkOutput("fc2_reload_done", 32'(bus2.o_state), 32'd0);
        checkOutput("fc2_reload_count", 32'(bus2.o_flush_count), 32'd2);

        // Three-cycle flush interrupted by a two-cycle memory stall.
        flush_cycles  = 0;
        freeze_cycles = 0;
        busy_pat      = 8'b0000_1100;
        for (int i = 0; i < 8; i++) begin
            bus3.i_branch_taken_EX = (i == 0);
            bus3.i_dmem_busy       = busy_pat[i];
            #1;
            if (bus3.o_flush_IFID)  flush_cycles++;
            if (bus3.o_pipe_freeze) freeze_cycles++;
            tick();
        end
        checkOutput("fc3_flush_cycles", 32'(flush_cycles), 32'd3);
        checkOutput("fc3_freeze_cycles", 32'(freeze_cycles), 32'd2);
        checkOutput("fc3_flush_count", 32'(bus3.o_flush_count), 32'd1);
        checkOutput("fc3_state_end", 32'(bus3.o_state), 32'd0);

        // Load-use stall, then rd=0 must not stall.
        applyStimulus(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_pc_write", 32'(bus1.o_pc_write), 32'd0);
        checkOutput("lu_ifid_write", 32'(bus1.o_IFID_write), 32'd0);
        checkOutput("lu_bubble", 32'(bus1.o_IDEX_bubble), 32'd1);
        tick();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_stall_count", 32'(bus1.o_stall_count), 32'd1);
        checkOutput("lu_bubble_cleared", 32'(bus1.o_IDEX_bubble), 32'd0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_rd0_bubble", 32'(bus1.o_IDEX_bubble), 32'd0);
        checkOutput("lu_rd0_pc_write", 32'(bus1.o_pc_write), 32'd1);
        tick();

        // Branch, load-use and busy together; busy held three cycles.
        applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("sim_freeze_%0d", k), 32'(bus1.o_pipe_freeze), 32'd1);
            checkOutput($sformatf("sim_noflush_%0d", k), 32'(bus1.o_flush_IFID), 32'd0);
            checkOutput($sformatf("sim_nobubble_%0d", k), 32'(bus1.o_IDEX_bubble), 32'd0);
            tick();
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("sim_state_freeze", 32'(bus1.o_state), 32'd2);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sim_release_flush", 32'(bus1.o_flush_IFID), 32'd1);
        checkOutput("sim_release_pc_write", 32'(bus1.o_pc_write), 32'd1);
        tick();
        checkOutput("sim_flush_count", 32'(bus1.o_flush_count), 32'd1);
        checkOutput("sim_stall_count", 32'(bus1.o_stall_count), 32'd1);
        checkOutput("sim_flush_once", 32'(bus1.o_flush_IFID), 32'd0);
        checkOutput("sim_state_run", 32'(bus1.o_state), 32'd0);

        // Twenty more load-use events saturate the 4-bit stall counter.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
            tick();
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("sat_stall_count", 32'(bus1.o_stall_count), 32'd15);

        // Reset while frozen with a branch pending.
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_pre_state", 32'(bus1.o_state), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_state", 32'(bus1.o_state), 32'd0);
        checkOutput("rst_async_stall", 32'(bus1.o_stall_count), 32'd0);
        checkOutput("rst_async_flush", 32'(bus1.o_flush_count), 32'd0);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_no_flush", 32'(bus1.o_flush_IFID), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        checkOutput("rst_post_state", 32'(bus1.o_state), 32'd0);
        checkOutput("rst_post_no_flush", 32'(bus1.o_flush_IFID), 32'd0);
        tick();
        checkOutput("rst_post_flush_count", 32'(bus1.o_flush_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
